// File: rtl/dm_access_ctrl.sv
// ============================================================================
// Module   : dm_access_ctrl
// Purpose  : Arbitrates and sequences the single-port data memory between the
//            MEM-stage CPU port and a DMA/loader port. Optional DMA starvation
//            guard is enabled by defining DM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_access_ctrl #(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_re_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [15:0] cpu_wdata_i,
    output logic [15:0] cpu_rdata_o,
    output logic        cpu_stall_o,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [15:0] dma_addr_i,
    input  logic [15:0] dma_wdata_i,
    output logic [15:0] dma_rdata_o,
    output logic        dma_ack_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    input  logic [15:0] mem_rdata_i,
    output logic        busy_o
);

    if (LAT < 1 || LAT > 8 || STARVE_MAX < 1) begin : g_param_check
        $error("dm_access_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(LAT - 1);

    state_t      state_q, state_d;
    logic        grant_dma_q, grant_dma_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;

    logic        cpu_req;
    logic        force_dma;
    logic        pick_dma;

    assign cpu_req  = cpu_re_i | cpu_we_i;
    assign pick_dma = dma_req_i & (~cpu_req | force_dma);

`ifdef DM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign force_dma = (starve_q == SW'(STARVE_MAX));

    // Counts back-to-back CPU grants that left a DMA request waiting.
    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (pick_dma) begin
                starve_d = '0;
            end else if (cpu_req) begin
                if (!dma_req_i) begin
                    starve_d = '0;
                end else if (!force_dma) begin
                    starve_d = starve_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_dma = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            grant_dma_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_dma_q <= grant_dma_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_dma_d = grant_dma_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || dma_req_i) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    if (pick_dma) begin
                        grant_dma_d = 1'b1;
                        we_d        = dma_we_i;
                        addr_d      = dma_addr_i;
                        wdata_d     = dma_wdata_i;
                    end else begin
                        // Simultaneous re/we from the CPU resolves to a write.
                        grant_dma_d = 1'b0;
                        we_d        = cpu_we_i;
                        addr_d      = cpu_addr_i;
                        wdata_d     = cpu_wdata_i;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (!we_q) begin
                        if (grant_dma_q) begin
                            dma_rdata_d = mem_rdata_i;
                        end else begin
                            cpu_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_re_o    = (state_q == S_ACCESS) & ~we_q;
    assign mem_we_o    = (state_q == S_ACCESS) & we_q;
    assign dma_ack_o   = (state_q == S_DONE) & grant_dma_q;
    assign busy_o      = (state_q != S_IDLE);
    assign cpu_stall_o = cpu_req & ~((state_q == S_DONE) & ~grant_dma_q);
    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;

`ifndef SYNTHESIS
    a_dma_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == S_ACCESS && grant_dma_q) |-> dma_req_i);
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
// ============================================================================
// Module   : tb_dm_access_ctrl
// Purpose  : Directed self-checking bench for dm_access_ctrl (LAT=2, STARVE_MAX=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_re, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, dma_ack, mem_re, mem_we, busy;

    logic [15:0] dm [0:65535];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) dm[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem_re ? dm[mem_addr] : 16'h0000;

    dm_access_ctrl #(.LAT(2), .STARVE_MAX(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cpu_re_i    (cpu_re),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .dma_req_i   (dma_req),
        .dma_we_i    (dma_we),
        .dma_addr_i  (dma_addr),
        .dma_wdata_i (dma_wdata),
        .dma_rdata_o (dma_rdata),
        .dma_ack_o   (dma_ack),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_re_o    (mem_re),
        .mem_we_o    (mem_we),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one CPU access and holds it until the stall drops (DONE cycle).
    task automatic run_cpu(input logic re, input logic we, input logic [15:0] a,
                           input logic [15:0] d, output int stalls, output int wes);
        logic done;
        cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        stalls = 0; wes = 0; done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!cpu_stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            if (mem_we) wes++;
            @(posedge clk);
        end
        if (!done) stalls = 99;
        cpu_re = 1'b0; cpu_we = 1'b0;
    endtask

    int st, wc, cyc, first_dma;
    logic got;

    initial begin
        rst_n = 1'b0;
        cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        dm[16'h0010] = 16'hBEEF;
        dm[16'h0030] = 16'hCAFE;
        dm[16'h0040] = 16'h4444;
        dm[16'h0060] = 16'h0000;
        dm[16'h0070] = 16'h0707;

        // Reset state
        #12;
        check("rst_busy",      16'(busy),      16'h0);
        check("rst_mem_re",    16'(mem_re),    16'h0);
        check("rst_mem_we",    16'(mem_we),    16'h0);
        check("rst_dma_ack",   16'(dma_ack),   16'h0);
        check("rst_mem_addr",  mem_addr,       16'h0000);
        check("rst_cpu_rdata", cpu_rdata,      16'h0000);
        check("rst_stall",     16'(cpu_stall), 16'h0);
        step();
        rst_n = 1'b1;
        step();

        // CPU read 0x0010: stall for LAT+1 cycles, data in DONE
        run_cpu(1'b1, 1'b0, 16'h0010, 16'h0000, st, wc);
        check("rd_stall_cycles", 16'(st), 16'd3);
        check("rd_rdata",        cpu_rdata, 16'hBEEF);
        check("rd_done_busy",    16'(busy), 16'h1);
        step();
        check("rd_idle_busy",    16'(busy), 16'h0);
        check("rd_addr_hold",    mem_addr,  16'h0010);
        check("rd_idle_re",      16'(mem_re), 16'h0);

        // CPU write then read back
        run_cpu(1'b0, 1'b1, 16'h0020, 16'h1234, st, wc);
        check("wr_stall_cycles", 16'(st), 16'd3);
        check("wr_we_cycles",    16'(wc), 16'd2);
        check("wr_rdata_keep",   cpu_rdata, 16'hBEEF);
        step();
        check("wr_mem",          dm[16'h0020], 16'h1234);
        run_cpu(1'b1, 1'b0, 16'h0020, 16'h0000, st, wc);
        check("rb_rdata",        cpu_rdata, 16'h1234);
        step();

        // re and we together behave as a write
        run_cpu(1'b1, 1'b1, 16'h0050, 16'h5555, st, wc);
        check("rw_we_cycles",    16'(wc), 16'd2);
        check("rw_rdata_keep",   cpu_rdata, 16'h1234);
        step();
        check("rw_mem",          dm[16'h0050], 16'h5555);

        // CPU and DMA request together: CPU first, DMA DONE four edges after CPU DONE
        cpu_re = 1; cpu_addr = 16'h0010;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0040;
        step(); step(); step();
        check("tie_cpu_done_stall", 16'(cpu_stall), 16'h0);
        check("tie_cpu_rdata",      cpu_rdata, 16'hBEEF);
        check("tie_no_ack_yet",     16'(dma_ack), 16'h0);
        cpu_re = 0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            if (dma_ack) break;
        end
        check("tie_ack_delay",  16'(cyc), 16'd4);
        check("tie_dma_rdata",  dma_rdata, 16'h4444);
        dma_req = 0;
        step();

        // DMA read while CPU idle
        dma_req = 1; dma_we = 0; dma_addr = 16'h0030;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            if (dma_ack) break;
        end
        check("dma_ack_delay", 16'(cyc), 16'd3);
        check("dma_rdata",     dma_rdata, 16'hCAFE);
        check("dma_cpu_stall", 16'(cpu_stall), 16'h0);
        dma_req = 0;
        step();
        check("dma_ack_pulse", 16'(dma_ack), 16'h0);
        check("dma_idle_busy", 16'(busy), 16'h0);

        // Continuous CPU traffic with a pending DMA write
        cpu_re = 1; cpu_addr = 16'h0010;
        dma_req = 1; dma_we = 1; dma_addr = 16'h0060; dma_wdata = 16'h6666;
        first_dma = -1;
        for (int k = 0; k < 6; k++) begin
            step();
            got = mem_we && (mem_addr == 16'h0060);
            if (got && first_dma < 0) first_dma = k;
            step(); step();
            if (got) dma_req = 0;
            step();
        end
`ifdef DM_ARB_STARVE_GUARD_EN
        check("starve_first_dma", 16'(first_dma), 16'd4);
`else
        check("starve_first_dma", 16'(first_dma), 16'hFFFF);
`endif
        cpu_re = 0;
        if (dma_req) begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (dma_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            check("gap_dma_acked", 16'(got), 16'h1);
            dma_req = 0;
        end
        step();
        check("starve_dma_mem", dm[16'h0060], 16'h6666);
        check("starve_cpu_rdata", cpu_rdata, 16'hBEEF);

        // Asynchronous reset in the middle of a CPU write
        cpu_we = 1; cpu_addr = 16'h0070; cpu_wdata = 16'h7777;
        step();
        check("arst_pre_we", 16'(mem_we), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_we",    16'(mem_we),    16'h0);
        check("arst_busy",      16'(busy),      16'h0);
        check("arst_dma_ack",   16'(dma_ack),   16'h0);
        check("arst_cpu_rdata", cpu_rdata,      16'h0000);
        check("arst_mem_addr",  mem_addr,       16'h0000);
        check("arst_stall",     16'(cpu_stall), 16'h1);
        step();
        cpu_we = 0;
        rst_n = 1'b1;
        step();
        check("arst_mem_kept",  dm[16'h0070], 16'h0707);
        check("arst_idle_busy", 16'(busy), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
